seg_reg_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage RV32I core: produces `en`/`clear` for the IF (PC), ID, EX, MEM and WB segment registers. Handles load-use hazards, taken-branch/jump flushes, and instruction- and data-cache miss stalls. Sits beside the hazard/forwarding logic and drives every segment register, including the ID/EX register, so that register never decides stall or flush on its own. Also keeps 32-bit stall and flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/seg_reg_ctrl_counter.sv | 16 +
 rtl/seg_reg_ctrl_load_use_detect.sv | 15 +
 rtl/seg_reg_ctrl.sv | 145 ++++++++++++++
 tb/tb_seg_reg_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    I_WAIT  = 2'd1,
    D_WAIT  = 2'd2,
    DI_WAIT = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic en;
    logic clear;
  } seg_ctl_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/seg_reg_ctrl_counter.sv
// Free-running event counter with synchronous clear; wraps at 2^W.
module perf_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seg_reg_ctrl_load_use_detect.sv
// Flags a load in EX whose destination feeds a source operand of the ID instruction.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] RdE,
  input  logic       MemToRegE,
  output logic       load_use
);

  assign load_use = MemToRegE && (RdE != REG_ZERO) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

endmodule

// File: rtl/seg_reg_ctrl.sv
// Segment register enable/clear sequencing for the five-stage core, with
// cache-miss tracking FSM and stall/flush performance counters.
module seg_reg_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             MemToRegE,
  input  logic             BranchE,
  input  logic             JalrE,
  input  logic             JalD,
  input  logic             icache_miss,
  input  logic             icache_done,
  input  logic             dcache_miss,
  input  logic             dcache_done,
  output logic             en_F,
  output logic             en_D,
  output logic             en_E,
  output logic             en_M,
  output logic             en_W,
  output logic             clear_D,
  output logic             clear_E,
  output logic             clear_M,
  output logic             clear_W,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_state_t state, state_nx;
  seg_ctl_t    d_ctl, e_ctl, m_ctl, w_ctl;
  logic        f_en;
  logic        load_use;
  logic        i_pend, d_pend, in_run;
  logic        d_freeze, i_block, i_stall, redirect;

  load_use_detect u_lu (
    .Rs1D      (Rs1D),
    .Rs2D      (Rs2D),
    .RdE       (RdE),
    .MemToRegE (MemToRegE),
    .load_use  (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN: begin
        if (dcache_miss && icache_miss) state_nx = DI_WAIT;
        else if (dcache_miss)           state_nx = D_WAIT;
        else if (icache_miss)           state_nx = I_WAIT;
      end
      I_WAIT: begin
        if (icache_done)      state_nx = RUN;
        else if (dcache_miss) state_nx = DI_WAIT;
      end
      D_WAIT: begin
        if (dcache_done) state_nx = icache_miss ? I_WAIT : RUN;
      end
      DI_WAIT: begin
        if (icache_done && dcache_done) state_nx = RUN;
        else if (icache_done)           state_nx = D_WAIT;
        else if (dcache_done)           state_nx = I_WAIT;
      end
      default: state_nx = RUN;
    endcase
  end

  assign in_run   = (state == RUN);
  assign i_pend   = (state == I_WAIT) || (state == DI_WAIT);
  assign d_pend   = (state == D_WAIT) || (state == DI_WAIT);
  assign d_freeze = (d_pend && !dcache_done) || (in_run && dcache_miss);
  assign i_block  = i_pend && !icache_done;
  // A done pulse only counts once the miss has been registered.
  assign i_stall  = i_block || (in_run && icache_miss);
  assign redirect = BranchE || JalrE;

  always_comb begin
    f_en  = 1'b1;
    d_ctl = '{en: 1'b1, clear: 1'b0};
    e_ctl = '{en: 1'b1, clear: 1'b0};
    m_ctl = '{en: 1'b1, clear: 1'b0};
    w_ctl = '{en: 1'b1, clear: 1'b0};
    if (!rst) begin
      if (d_freeze) begin
        f_en  = 1'b0;
        d_ctl = '0;
        e_ctl = '0;
        m_ctl = '0;
        w_ctl = '0;
      end else if (i_block && redirect) begin
        f_en        = 1'b0;
        d_ctl.en    = 1'b0;
        e_ctl.en    = 1'b0;
        m_ctl.clear = 1'b1;
      end else if (redirect) begin
        d_ctl.clear = 1'b1;
        e_ctl.clear = 1'b1;
      end else if (JalD) begin
        d_ctl.clear = 1'b1;
      end else if (load_use) begin
        f_en        = 1'b0;
        d_ctl.en    = 1'b0;
        e_ctl.clear = 1'b1;
      end else if (i_stall) begin
        f_en        = 1'b0;
        d_ctl.clear = 1'b1;
      end
    end
  end

  assign en_F    = f_en;
  assign en_D    = d_ctl.en;
  assign en_E    = e_ctl.en;
  assign en_M    = m_ctl.en;
  assign en_W    = w_ctl.en;
  assign clear_D = d_ctl.clear;
  assign clear_E = e_ctl.clear;
  assign clear_M = m_ctl.clear;
  assign clear_W = w_ctl.clear;

  perf_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (!(en_F && en_D && en_E && en_M && en_W)),
    .cnt (stall_cnt)
  );

  perf_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (clear_D || clear_E),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_seg_reg_ctrl.sv
// Directed and randomized check of seg_reg_ctrl against a flag-based reference model.
module tb_seg_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, RdE;
  logic       MemToRegE, BranchE, JalrE, JalD;
  logic       icache_miss, icache_done, dcache_miss, dcache_done;

  logic [8:0]  o1, o4;
  logic [31:0] stall_cnt, flush_cnt;
  logic [3:0]  stall4, flush4;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  // Reference model: pending-miss flags and counters.
  logic        m_ipend, m_dpend;
  logic [31:0] m_stall, m_flush;

  always #5 clk = ~clk;

  seg_reg_ctrl dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .MemToRegE(MemToRegE), .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD),
    .icache_miss(icache_miss), .icache_done(icache_done),
    .dcache_miss(dcache_miss), .dcache_done(dcache_done),
    .en_F(o1[8]), .en_D(o1[7]), .en_E(o1[6]), .en_M(o1[5]), .en_W(o1[4]),
    .clear_D(o1[3]), .clear_E(o1[2]), .clear_M(o1[1]), .clear_W(o1[0]),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  seg_reg_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .MemToRegE(MemToRegE), .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD),
    .icache_miss(icache_miss), .icache_done(icache_done),
    .dcache_miss(dcache_miss), .dcache_done(dcache_done),
    .en_F(o4[8]), .en_D(o4[7]), .en_E(o4[6]), .en_M(o4[5]), .en_W(o4[4]),
    .clear_D(o4[3]), .clear_E(o4[2]), .clear_M(o4[1]), .clear_W(o4[0]),
    .stall_cnt(stall4), .flush_cnt(flush4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output vector {en_F,en_D,en_E,en_M,en_W,clear_D,clear_E,clear_M,clear_W}
  // derived directly from the priority rules.
  function automatic logic [8:0] model_out();
    logic run, dfz, redir, iwait, lu, istall;
    logic [8:0] o;
    o = 9'b11111_0000;
    if (!rst) begin
      run    = !m_ipend && !m_dpend;
      dfz    = (m_dpend && !dcache_done) || (run && dcache_miss);
      redir  = BranchE || JalrE;
      iwait  = m_ipend && !icache_done;
      lu     = MemToRegE && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
      istall = iwait || (run && icache_miss);
      if (dfz)                o = 9'b00000_0000;
      else if (iwait && redir) o = 9'b00011_0010;
      else if (redir)         o = 9'b11111_1100;
      else if (JalD)          o = 9'b11111_1000;
      else if (lu)            o = 9'b00111_0100;
      else if (istall)        o = 9'b01111_1000;
    end
    return o;
  endfunction

  // One clock: check at negedge, advance model, step past posedge.
  task automatic cycle(input string tag = "", input logic [8:0] want = '0, input bit chk = 1'b0);
    logic [8:0] e;
    logic ni, nd;
    e = model_out();
    @(negedge clk);
    if (chk) check(tag, o1, want);
    check("outs", o1, e);
    check("outs_w4", o4, e);
    check("state", 64'(dut.state), {m_dpend, m_ipend});
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
    check("stall_cnt_w4", stall4, m_stall[3:0]);
    check("flush_cnt_w4", flush4, m_flush[3:0]);
    ni = m_ipend;
    nd = m_dpend;
    if (rst) begin
      ni = 0; nd = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (e[8:4] != 5'b11111) m_stall = m_stall + 1;
      if (e[3] || e[2])       m_flush = m_flush + 1;
      if (!m_ipend && !m_dpend) begin
        ni = icache_miss; nd = dcache_miss;
      end else if (m_ipend && !m_dpend) begin
        if (icache_done) ni = 0;
        else if (dcache_miss) nd = 1;
      end else if (!m_ipend && m_dpend) begin
        if (dcache_done) begin nd = 0; ni = icache_miss; end
      end else begin
        ni = !icache_done; nd = !dcache_done;
      end
    end
    m_ipend = ni;
    m_dpend = nd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; Rs1D = 0; Rs2D = 0; RdE = 0; MemToRegE = 0; BranchE = 0;
    JalrE = 0; JalD = 0; icache_miss = 0; icache_done = 0;
    dcache_miss = 0; dcache_done = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    BranchE = 1; dcache_miss = 1; MemToRegE = 1;
    cycle("rst_outs", 9'b11111_0000, 1);
    idle();
  endtask

  initial begin
    m_ipend = 0; m_dpend = 0; m_stall = 0; m_flush = 0;
    do_reset();
    cycle("idle", 9'b11111_0000, 1);
    check("rst_stall", stall_cnt, 0);

    // Load-use, then same with RdE=0
    RdE = 5; MemToRegE = 1; Rs2D = 5;
    cycle("lu", 9'b00111_0100, 1);
    check("lu_stall", stall_cnt, 1);
    RdE = 0; Rs2D = 0;
    cycle("lu_x0", 9'b11111_0000, 1);
    check("lu_x0_stall", stall_cnt, 1);
    idle();

    // Branch in RUN
    BranchE = 1;
    cycle("br", 9'b11111_1100, 1);
    check("br_flush", flush_cnt, 2);
    idle();

    // D-miss for 4 cycles, done in the 4th
    do_reset();
    dcache_miss = 1;
    for (int i = 0; i < 3; i++) cycle("dm_frz", 9'b00000_0000, 1);
    dcache_done = 1;
    cycle("dm_done", 9'b11111_0000, 1);
    idle();
    cycle("dm_after", 9'b11111_0000, 1);
    check("dm_stall", stall_cnt, 3);

    // I-miss, D-miss two cycles later, I done before D done
    do_reset();
    icache_miss = 1;
    cycle("id_i0", 9'b01111_1000, 1);
    cycle("id_i1", 9'b01111_1000, 1);
    dcache_miss = 1;
    cycle("id_i2", 9'b01111_1000, 1);
    cycle("id_di", 9'b00000_0000, 1);
    icache_done = 1;
    cycle("id_idone", 9'b00000_0000, 1);
    icache_done = 0; icache_miss = 0;
    cycle("id_dw", 9'b00000_0000, 1);
    dcache_done = 1;
    cycle("id_ddone", 9'b11111_0000, 1);
    idle();
    cycle("id_run", 9'b11111_0000, 1);

    // Branch blocked during I-miss
    do_reset();
    icache_miss = 1;
    cycle("bi_i0", 9'b01111_1000, 1);
    BranchE = 1;
    for (int i = 0; i < 3; i++) cycle("bi_blk", 9'b00011_0010, 1);
    icache_done = 1;
    cycle("bi_done", 9'b11111_1100, 1);
    idle();
    cycle("bi_run", 9'b11111_0000, 1);

    // Reset during D_WAIT, then a stray done in RUN
    dcache_miss = 1;
    cycle("rd_frz", 9'b00000_0000, 1);
    cycle("rd_frz2", 9'b00000_0000, 1);
    rst = 1;
    cycle("rd_rst", 9'b11111_0000, 1);
    idle();
    dcache_done = 1;
    cycle("rd_stray", 9'b11111_0000, 1);
    check("rd_stall", stall_cnt, 0);
    idle();
    cycle("rd_run", 9'b11111_0000, 1);

    // Randomized traffic with well-behaved cache handshakes
    for (int n = 0; n < 4000; n++) begin
      logic idone_last, ddone_last;
      idone_last = icache_done;
      ddone_last = dcache_done;
      rst       = ($urandom_range(0, 299) == 0);
      Rs1D      = 5'($urandom_range(0, 3));
      Rs2D      = 5'($urandom_range(0, 3));
      RdE       = 5'($urandom_range(0, 3));
      MemToRegE = ($urandom_range(0, 2) == 0);
      BranchE   = ($urandom_range(0, 6) == 0);
      JalrE     = ($urandom_range(0, 15) == 0);
      JalD      = ($urandom_range(0, 9) == 0);
      if (idone_last)        icache_miss = 0;
      else if (!icache_miss) icache_miss = ($urandom_range(0, 9) == 0);
      if (ddone_last)        dcache_miss = 0;
      else if (!dcache_miss) dcache_miss = ($urandom_range(0, 11) == 0);
      icache_done = (icache_miss && m_ipend && $urandom_range(0, 3) == 0) ||
                    (!icache_miss && $urandom_range(0, 19) == 0);
      dcache_done = (dcache_miss && m_dpend && $urandom_range(0, 2) == 0) ||
                    (!dcache_miss && !m_dpend && $urandom_range(0, 19) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
